// File: rtl/raster_stamp_csr_pkg.sv
// Shared raster stamp types: stamp layout, per-lane CSR storage, CSR offset map.
// Latency: n/a (types and a combinational packing helper only).
// Backpressure: n/a.
package VX_raster_types;

    localparam int RASTER_DIM_BITS = 8;
    localparam int POS_W           = RASTER_DIM_BITS - 1;

    // CSR offsets within the raster CSR block
    localparam int CSR_OFF_POS_MASK = 0;
    localparam int CSR_OFF_BCOORD   = 1;   // bcoords[i][j] at CSR_OFF_BCOORD + 4*i + j
    localparam int NUM_BCOORD_CSRS  = 12;

    typedef struct packed {
        logic [POS_W-1:0]        pos_x;
        logic [POS_W-1:0]        pos_y;
        logic [3:0]              mask;
        logic [2:0][3:0][31:0]   bcoords;
        logic [15:0]             pid;
    } raster_stamp_t;

    // Per-lane CSR view of one stamp
    typedef struct packed {
        logic [31:0]             pos_mask;
        logic [2:0][3:0][31:0]   bcoords;
    } raster_csrs_t;

    // mask in [3:0], pos_x above it, pos_y above that, zero-extended
    function automatic logic [31:0] pack_pos_mask(input raster_stamp_t s);
        return 32'({s.pos_y, s.pos_x, s.mask});
    endfunction

endpackage

// File: rtl/raster_stamp_csr_store.sv
// raster_stamp_store: NUM_WARPS x NUM_LANES stamp CSR array, one write port, one read port.
// Latency: write visible next cycle; read data registered, valid the cycle after rd_en_i.
// Backpressure: none, both ports accept every cycle. Bcoords kept only with RASTER_STAMP_BCOORDS_EN.
// Ports: wr_en_i/wr_wid_i/wr_lane_i/wr_clear_i/wr_data_i write (clear wins over data);
//        rd_en_i/rd_wid_i/rd_off_i read strobe, rd_data_o per-lane 32-bit CSR value.
module raster_stamp_store
    import VX_raster_types::*;
#(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_LANES    = 4,
    parameter int CSR_OFF_BITS = 4,
    parameter int WID_W        = 2,
    parameter int LANE_W       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en_i,
    input  logic [WID_W-1:0]              wr_wid_i,
    input  logic [LANE_W-1:0]             wr_lane_i,
    input  logic                          wr_clear_i,
    input  raster_csrs_t                  wr_data_i,
    input  logic                          rd_en_i,
    input  logic [WID_W-1:0]              rd_wid_i,
    input  logic [CSR_OFF_BITS-1:0]       rd_off_i,
    output logic [NUM_LANES-1:0][31:0]    rd_data_o
);

    logic [NUM_WARPS-1:0][NUM_LANES-1:0][31:0] pos_q;
    logic [NUM_LANES-1:0][31:0]                rd_d, rd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q <= '0;
        end else if (wr_en_i) begin
            pos_q[wr_wid_i][wr_lane_i] <= wr_clear_i ? 32'h0 : wr_data_i.pos_mask;
        end
    end

`ifdef RASTER_STAMP_BCOORDS_EN
    logic [NUM_WARPS-1:0][NUM_LANES-1:0][2:0][3:0][31:0] bc_q;
    logic [CSR_OFF_BITS-1:0]                             bc_idx;
    logic                                                bc_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bc_q <= '0;
        end else if (wr_en_i) begin
            bc_q[wr_wid_i][wr_lane_i] <= wr_clear_i ? '0 : wr_data_i.bcoords;
        end
    end

    assign bc_idx = rd_off_i - CSR_OFF_BITS'(CSR_OFF_BCOORD);
    assign bc_hit = (rd_off_i >= CSR_OFF_BITS'(CSR_OFF_BCOORD)) &&
                    (rd_off_i <= CSR_OFF_BITS'(CSR_OFF_BCOORD + NUM_BCOORD_CSRS - 1));
`else
    // bcoords arrive on the write port but have no storage in this build
    logic unused_bcoords;
    assign unused_bcoords = ^wr_data_i.bcoords;
`endif

    always_comb begin
        rd_d = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (rd_off_i == CSR_OFF_BITS'(CSR_OFF_POS_MASK)) begin
                rd_d[l] = pos_q[rd_wid_i][l];
            end
`ifdef RASTER_STAMP_BCOORDS_EN
            else if (bc_hit) begin
                rd_d[l] = bc_q[rd_wid_i][l][bc_idx[3:2]][bc_idx[1:0]];
            end
`endif
        end
    end

    // Holds last read result until the next strobe; a same-cycle write is not forwarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= rd_d;
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/raster_stamp_csr.sv
// raster_stamp_csr: pops one raster stamp per active lane on a fetch, stores it as lane CSRs.
// Latency: k active lanes with stamps ready -> response k+1 cycles after accept; CSR read 1 cycle.
// Backpressure: fetch_ready only in IDLE; stamps wait in GATHER; response held until rsp_ready.
// Ports: stamp_valid/stamp_data/stamp_ready/raster_done from raster unit; fetch_* request;
//        rsp_* result; csr_rd_* read port. Optional macro: RASTER_STAMP_BCOORDS_EN.
module raster_stamp_csr
    import VX_raster_types::*;
#(
    parameter int  NUM_WARPS    = 4,
    parameter int  NUM_LANES    = 4,
    parameter int  CSR_OFF_BITS = 4,
    localparam int WID_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stamp_valid,
    input  raster_stamp_t                 stamp_data,
    output logic                          stamp_ready,
    input  logic                          raster_done,
    input  logic                          fetch_valid,
    input  logic [WID_W-1:0]              fetch_wid,
    input  logic [NUM_LANES-1:0]          fetch_tmask,
    output logic                          fetch_ready,
    output logic                          rsp_valid,
    output logic [WID_W-1:0]              rsp_wid,
    output logic [NUM_LANES-1:0][31:0]    rsp_data,
    input  logic                          rsp_ready,
    input  logic                          csr_rd_valid,
    input  logic [WID_W-1:0]              csr_rd_wid,
    input  logic [CSR_OFF_BITS-1:0]       csr_rd_off,
    output logic [NUM_LANES-1:0][31:0]    csr_rd_data
);

    if (4 + 2 * (RASTER_DIM_BITS - 1) > 32) begin : g_pos_mask_too_wide
        $error("raster_stamp_csr: pos_mask packing exceeds 32 bits");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GATHER = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [WID_W-1:0]           wid_q, wid_d;
    logic [NUM_LANES-1:0]       pend_q, pend_d;   // active lanes still awaiting a stamp
    logic [NUM_LANES-1:0][31:0] rsp_q, rsp_d;
    logic [LANE_W-1:0]          cur_lane;
    logic                       serve;
    raster_csrs_t               wr_data;

    // Current lane is the lowest still-pending lane
    always_comb begin
        cur_lane = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (pend_q[l]) cur_lane = LANE_W'(l);
        end
    end

    // stamp_valid outranks raster_done; either one retires the current lane
    assign serve = (state_q == ST_GATHER) && (stamp_valid || raster_done);

    always_comb begin
        state_d = state_q;
        wid_d   = wid_q;
        pend_d  = pend_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_valid) begin
                    wid_d   = fetch_wid;
                    pend_d  = fetch_tmask;
                    rsp_d   = '0;
                    state_d = (fetch_tmask == '0) ? ST_RESP : ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (serve) begin
                    rsp_d[cur_lane]  = stamp_valid ? {15'b0, 1'b1, stamp_data.pid} : 32'h0;
                    pend_d[cur_lane] = 1'b0;
                    if (pend_d == '0) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wid_q   <= '0;
            pend_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            wid_q   <= wid_d;
            pend_q  <= pend_d;
            rsp_q   <= rsp_d;
        end
    end

    assign wr_data.pos_mask = pack_pos_mask(stamp_data);
    assign wr_data.bcoords  = stamp_data.bcoords;

    raster_stamp_store #(
        .NUM_WARPS    (NUM_WARPS),
        .NUM_LANES    (NUM_LANES),
        .CSR_OFF_BITS (CSR_OFF_BITS),
        .WID_W        (WID_W),
        .LANE_W       (LANE_W)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (serve),
        .wr_wid_i   (wid_q),
        .wr_lane_i  (cur_lane),
        .wr_clear_i (!stamp_valid),
        .wr_data_i  (wr_data),
        .rd_en_i    (csr_rd_valid),
        .rd_wid_i   (csr_rd_wid),
        .rd_off_i   (csr_rd_off),
        .rd_data_o  (csr_rd_data)
    );

    assign stamp_ready = (state_q == ST_GATHER) && stamp_valid;
    assign fetch_ready = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_wid     = wid_q;
    assign rsp_data    = rsp_q;

endmodule

// File: tb/tb_raster_stamp_csr.sv
// tb_raster_stamp_csr: directed bench with a response scoreboard and a CSR storage model.
// Latency: n/a. Backpressure: exercises stamp gaps, raster_done and held rsp_ready.
module tb_raster_stamp_csr;
    import VX_raster_types::*;

`ifdef RASTER_STAMP_BCOORDS_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          stamp_valid;
    raster_stamp_t stamp_data;
    logic          stamp_ready;
    logic          raster_done;
    logic          fetch_valid;
    logic [1:0]    fetch_wid;
    logic [3:0]    fetch_tmask;
    logic          fetch_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_wid;
    logic [3:0][31:0] rsp_data;
    logic          rsp_ready;
    logic          csr_rd_valid;
    logic [1:0]    csr_rd_wid;
    logic [3:0]    csr_rd_off;
    logic [3:0][31:0] csr_rd_data;

    always #5 clk = ~clk;

    raster_stamp_csr #(.NUM_WARPS(4), .NUM_LANES(4), .CSR_OFF_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .stamp_valid(stamp_valid), .stamp_data(stamp_data), .stamp_ready(stamp_ready),
        .raster_done(raster_done),
        .fetch_valid(fetch_valid), .fetch_wid(fetch_wid), .fetch_tmask(fetch_tmask),
        .fetch_ready(fetch_ready),
        .rsp_valid(rsp_valid), .rsp_wid(rsp_wid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .csr_rd_valid(csr_rd_valid), .csr_rd_wid(csr_rd_wid), .csr_rd_off(csr_rd_off),
        .csr_rd_data(csr_rd_data)
    );

    typedef struct {
        logic [1:0]   wid;
        logic [127:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] m_pos [4][4];
    logic [31:0] m_bc  [4][4][12];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic raster_stamp_t mk(input int pid);
        raster_stamp_t s;
        s       = '0;
        s.pid   = 16'(pid);
        s.mask  = 4'(pid);
        s.pos_x = POS_W'(pid * 3);
        s.pos_y = POS_W'(pid + 1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                s.bcoords[i][j] = {16'(pid), 8'(i), 8'(j)};
        return s;
    endfunction

    // Independent arithmetic form of the packed pos_mask: mask | pos_x<<4 | pos_y<<11
    function automatic logic [31:0] exp_pos(input int pid);
        return 32'((pid & 15) | (((pid * 3) & 127) << 4) | (((pid + 1) & 127) << 11));
    endfunction

    function automatic logic [31:0] exp_bc(input int pid, input int i, input int j);
        return 32'(((pid & 16'hffff) << 16) | (i << 8) | j);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input int w, input int off);
        logic [127:0] e;
        e = '0;
        csr_rd_valid = 1'b1;
        csr_rd_wid   = 2'(w);
        csr_rd_off   = 4'(off);
        tick();
        csr_rd_valid = 1'b0;
        for (int l = 0; l < 4; l++) begin
            if (off == 0)                        e[l*32 +: 32] = m_pos[w][l];
            else if (BC_EN && off >= 1 && off <= 12) e[l*32 +: 32] = m_bc[w][l][off-1];
        end
        chk($sformatf("csr_w%0d_off%0d", w, off), csr_rd_data, e);
    endtask

    task automatic clear_model();
        for (int w = 0; w < 4; w++)
            for (int l = 0; l < 4; l++) begin
                m_pos[w][l] = '0;
                for (int k = 0; k < 12; k++) m_bc[w][l][k] = '0;
            end
    endtask

    // First nst active lanes get stamps pid0, pid0+1, ...; the rest are retired via raster_done.
    task automatic fetch(input int w, input logic [3:0] tm, input int nst, input bit tog,
                         input int pid0, input int hold);
        rsp_t         r;
        rsp_t         got;
        int           s;
        int           pops;
        int           cyc;
        int           pid;
        logic [127:0] ed;
        s  = 0;
        ed = '0;
        for (int l = 0; l < 4; l++) begin
            if (tm[l]) begin
                if (s < nst) begin
                    ed[l*32 +: 32] = 32'h10000 | 32'(pid0 + s);
                    m_pos[w][l]    = exp_pos(pid0 + s);
                    for (int k = 0; k < 12; k++) m_bc[w][l][k] = exp_bc(pid0 + s, k / 4, k % 4);
                    s++;
                end else begin
                    m_pos[w][l] = '0;
                    for (int k = 0; k < 12; k++) m_bc[w][l][k] = '0;
                end
            end
        end
        r.wid  = 2'(w);
        r.data = ed;
        sb.push_back(r);

        chk("fetch_ready_idle", fetch_ready, 1);
        fetch_valid = 1'b1;
        fetch_wid   = 2'(w);
        fetch_tmask = tm;
        tick();
        fetch_valid = 1'b0;

        pops = 0;
        cyc  = 1;
        pid  = pid0;
        while (!rsp_valid && cyc < 40) begin
            stamp_data  = mk(pid);
            stamp_valid = (pops < nst) && (!tog || cyc[0]);
            raster_done = (pops >= nst);
            #1;
            if (stamp_ready) begin
                pops++;
                pid++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        stamp_valid = 1'b0;
        raster_done = 1'b0;
        chk("rsp_valid_seen", rsp_valid, 1);
        chk("pop_count", pops, s);
        if (!tog) chk("rsp_latency", cyc, $countones(tm) + 1);

        for (int h = 0; h < hold; h++) begin
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_data", rsp_data, sb[0].data);
            chk("hold_fetch_ready", fetch_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        got = sb.pop_front();
        chk("rsp_wid", rsp_wid, got.wid);
        chk("rsp_data", rsp_data, got.data);
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        stamp_valid  = 1'b0;
        stamp_data   = '0;
        raster_done  = 1'b0;
        fetch_valid  = 1'b0;
        fetch_wid    = '0;
        fetch_tmask  = '0;
        rsp_ready    = 1'b0;
        csr_rd_valid = 1'b0;
        csr_rd_wid   = '0;
        csr_rd_off   = '0;
        clear_model();
        #1;
        chk("rst_stamp_ready", stamp_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_wid", rsp_wid, 0);
        chk("rst_csr_rd_data", csr_rd_data, 0);
        chk("rst_fetch_ready", fetch_ready, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // all four lanes, stamps always valid
        fetch(0, 4'b1111, 4, 1'b0, 5, 0);
        csr_read(0, 0);
        csr_read(0, 5);
        csr_read(0, 12);

        // partial mask with gaps in stamp_valid; lanes 0,2 keep earlier contents
        fetch(1, 4'b1111, 4, 1'b0, 30, 0);
        fetch(1, 4'b1010, 2, 1'b1, 20, 0);
        csr_read(1, 0);
        csr_read(1, 5);

        // raster_done retires lanes without popping and clears their CSRs
        fetch(2, 4'b1111, 4, 1'b0, 50, 0);
        fetch(2, 4'b0111, 1, 1'b0, 40, 0);
        csr_read(2, 0);
        csr_read(2, 5);
        csr_read(2, 14);

        // empty mask, response held under backpressure
        fetch(3, 4'b0000, 0, 1'b0, 70, 3);
        csr_read(3, 0);

        // reset in the middle of a gather
        csr_read(0, 0);
        fetch_valid = 1'b1;
        fetch_wid   = 2'd3;
        fetch_tmask = 4'b1111;
        tick();
        fetch_valid = 1'b0;
        stamp_valid = 1'b1;
        stamp_data  = mk(60);
        #1;
        chk("mid_pop0", stamp_ready, 1);
        tick();
        stamp_data = mk(61);
        #1;
        chk("mid_pop1", stamp_ready, 1);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_stamp_ready", stamp_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_rsp_wid", rsp_wid, 0);
        chk("mid_rst_csr_rd_data", csr_rd_data, 0);
        stamp_valid = 1'b0;
        clear_model();
        sb.delete();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_fetch_ready", fetch_ready, 1);
        for (int w = 0; w < 4; w++)
            for (int off = 0; off < 16; off++)
                csr_read(w, off);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/raster_stamp_csr.md
# raster_stamp_csr

Consumer end of the raster stamp stream: accepts `raster_stamp_t` stamps from the raster unit, distributes one stamp per active lane of a warp on a raster-fetch request, and holds each lane's stamp as `raster_csrs_t` (pos_mask plus barycentrics) for shader CSR reads. It sits between the raster unit output and the core's CSR/SFU path, the other side of the stamp interface.

## Interface
- NUM_WARPS, 4, warps with independent stamp storage
- NUM_LANES, 4, threads per warp
- CSR_OFF_BITS, 4, CSR offset width within the raster CSR block
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stamp_valid  in  1  stamp available
- stamp_data  in  $bits(raster_stamp_t)  stamp from raster unit
- stamp_ready  out  1  stamp popped this cycle
- raster_done  in  1  raster unit has no more stamps
- fetch_valid  in  1  raster-fetch request
- fetch_wid  in  log2(NUM_WARPS)  requesting warp
- fetch_tmask  in  NUM_LANES  active lanes
- fetch_ready  out  1  request accepted
- rsp_valid  out  1  fetch result valid
- rsp_wid  out  log2(NUM_WARPS)  warp of result
- rsp_data  out  NUM_LANES x 32  per-lane result
- rsp_ready  in  1  result consumed
- csr_rd_valid  in  1  CSR read strobe
- csr_rd_wid  in  log2(NUM_WARPS)  warp read
- csr_rd_off  in  CSR_OFF_BITS  CSR offset
- csr_rd_data  out  NUM_LANES x 32  per-lane CSR value

## Operation
- FSM: IDLE, GATHER, RESP. fetch_ready = (state==IDLE).
- Accept in IDLE on fetch_valid: latch wid, tmask; lane pointer = lowest set bit; tmask==0 goes to RESP, else GATHER.
- GATHER, current lane L: stamp_valid=1 -> stamp_ready=1, store[wid][L] = {pos_mask, bcoords}, rsp lane L = {15'b0, 1'b1, pid}. Else raster_done=1 -> store[wid][L] cleared to 0, rsp lane L = 0. Else wait. stamp_valid outranks raster_done. Pointer moves to next set bit; after last active lane -> RESP.
- stamp_ready is 0 outside GATHER.
- pos_mask packing: [3:0]=mask, then pos_x, then pos_y (RASTER_DIM_BITS-1 bits each), zero-extended to 32; elaboration error if 4+2*(RASTER_DIM_BITS-1) > 32.
- Inactive lanes: storage untouched, rsp_data lane = 0.
- RESP: rsp_valid=1, rsp_wid/rsp_data stable until rsp_ready; then IDLE.
- CSR offsets: 0=pos_mask, 1+4*i+j = bcoords[i][j] (i<3, j<4); offsets 13..15 read 0.

## Timing
- Fetch accepted cycle T, k active lanes, stamps always valid: pops at T+1..T+k, rsp_valid at T+k+1. k=0: rsp_valid at T+1.
- At most one stamp per cycle.
- CSR read: csr_rd_data registered, valid cycle after strobe; never stalls. Same-cycle write to the read entry returns old data.
- Reset (async assert, any state): state IDLE, storage zero, stamp_ready/rsp_valid/rsp_wid/rsp_data/csr_rd_data 0. Mid-GATHER reset drops the fetch; already-popped stamps are lost.

## Configuration
- RASTER_STAMP_BCOORDS_EN defined: bcoords stored and readable at offsets 1..12.
- Undefined: only pos_mask stored (bcoords storage not built); offsets 1..15 read 0; fetch handshakes unchanged.

## Structure
- Add to shared package VX_raster_types: CSR offset constants (POS_MASK, BCOORD base), pos_mask packing function, per-lane storage typedef.
- One sub-module: raster_stamp_store — NUM_WARPS x NUM_LANES entry array, one write port (wid, lane, data, clear), one registered read port (wid, offset -> NUM_LANES x 32).

## Test plan
- tmask=4'b1111, four stamps pid 5..8 ready -> rsp at T+5, rsp_data = {0x10008,0x10007,0x10006,0x10005}; CSR off 0 lane 2 = packed pos_mask of pid 7.
- tmask=4'b1010, stamp_valid toggling 1/0 -> exactly two pops to lanes 1,3; lanes 0,2 rsp 0, CSR unchanged.
- One stamp then stamp_valid=0, raster_done=1, tmask=4'b0111 -> lane 0 loaded, lanes 1,2 rsp 0 and CSRs cleared, no extra pop.
- tmask=0 -> rsp_valid at T+1, rsp_data all 0, stamp_ready never high; rsp_ready held 0 three cycles -> rsp stable, fetch_ready 0.
- CSR read off 5 (bcoords[1][0]) wid 2 after fetch -> stored value; off 14 -> 0; with macro undefined off 5 -> 0.
- Reset asserted mid-GATHER after 2 pops -> outputs 0 immediately, all CSR reads 0 after release, fetch_ready 1.
